gate_controller: RTL
====================

# gate_controller

Barrier-gate front end that drives the parking manager's event inputs (`car_entered`/`is_uni_car_entered`, `car_exited`/`is_uni_car_exited`) and consumes its `rejected`/`rejected_uni` flags. It serialises entry-lane and exit-lane requests into single-cycle events and decides from the manager's response whether to raise a barrier. It then times the barrier open and re-arms only once the car has left the lane loop. It sits between the lane sensors and the parking manager.

## Interface
- `OPEN_TIMEOUT`, 700: max cycles a barrier stays open waiting for the pass sensor.
- `RESP_DELAY`, 1: cycles between the event pulse and sampling of `rejected`/`rejected_uni` (≥1).
- `TMO_W`, 8: width of `timeout_count`.
- `CLK` in 1: clock, rising edge.
- `Start` in 1: synchronous active-high reset.
- `entry_req` in 1: level, car on entry loop.
- `entry_uni` in 1: entry car is university class; sampled at grant.
- `exit_req` in 1: level, car on exit loop.
- `exit_uni` in 1: exit car is university class; sampled at grant.
- `entry_pass` in 1: entry barrier pass sensor.
- `exit_pass` in 1: exit barrier pass sensor.
- `rejected` in 1: manager response, general class.
- `rejected_uni` in 1: manager response, university class.
- `car_entered` out 1: one-cycle entry event.
- `is_uni_car_entered` out 1: class qualifier, valid only with `car_entered`.
- `car_exited` out 1: one-cycle exit event.
- `is_uni_car_exited` out 1: class qualifier, valid only with `car_exited`.
- `entry_open` out 1: entry barrier raised.
- `exit_open` out 1: exit barrier raised.
- `entry_denied` out 1: one-cycle pulse on entry rejection.
- `exit_denied` out 1: one-cycle pulse on exit rejection.
- `busy` out 1: FSM not in IDLE.
- `timeout_count` out TMO_W: saturating count of barrier timeouts.

## Operation
- Single shared FSM. States: IDLE, ISSUE, WAIT, OPEN, DENY, REVERT, CLEAR.
- IDLE:
  - If exactly one of `entry_req`/`exit_req` is high, grant that lane.
  - If both are high, grant the lane opposite `last_grant` (round-robin).
  - On grant, latch lane and class (`*_uni`), update `last_grant`, and go to ISSUE.
- ISSUE: pulse the lane's event and class qualifier for exactly one cycle, then go to WAIT.
- WAIT:
  - Count RESP_DELAY cycles, then sample `rejected_uni` if the latched class is uni, else `rejected`.
  - Sample 1 → DENY. Sample 0 → OPEN with timer cleared.
- DENY: pulse the lane's `*_denied` for one cycle, then go to CLEAR. The barrier never opens.
- OPEN:
  - Hold the lane's `*_open` high; the timer increments each cycle.
  - Lane pass sensor = 1 → CLEAR.
  - Otherwise, timer reaching OPEN_TIMEOUT−1 → `timeout_count` +1 (saturating at all-ones), then go to REVERT if `GATE_TIMEOUT_REVERT_EN` is defined, else CLEAR.
  - The pass sensor wins if it coincides with the timeout cycle.
- REVERT: pulse the opposite event for one cycle, with the same class (entry lane → `car_exited`; exit lane → `car_entered`), then go to CLEAR. The manager's response to this pulse is ignored.
- CLEAR: barrier low. Stay until the granted lane's `*_req` = 0, then return to IDLE. This prevents double counting of one car.
- At most one of `car_entered`/`car_exited` is high in any cycle. Requests on the other lane wait in IDLE and are never dropped while held.

## Timing
- All outputs are registered.
- `Start` = 1 at a clock edge, including mid-operation, forces:
  - state IDLE, timer 0, `last_grant` = exit (so entry wins the first tie);
  - all event, qualifier, open, denied and busy outputs to 0, and `timeout_count` to 0.
- Grant at edge N:
  - event pulse visible in cycle N+1;
  - response sampled at edge N+1+RESP_DELAY;
  - `*_open` or `*_denied` asserted in the following cycle.
- With RESP_DELAY = 1, a barrier opens 3 cycles after the request is seen.
- Barrier open duration ≤ OPEN_TIMEOUT cycles.
- `busy` = 1 from the cycle after grant until IDLE is re-entered.

## Configuration
- `GATE_TIMEOUT_REVERT_EN`:
  - Defined: a timeout issues a compensating opposite-direction event (REVERT) so the manager's counts match physical occupancy.
  - Undefined: the REVERT state is not built; a timeout only increments `timeout_count` and goes to CLEAR.

## Test plan
- Reset then `entry_req`=1, `entry_uni`=0, `rejected`=0 → `car_entered` pulses 1 cycle with `is_uni_car_entered`=0; `entry_open`=1 three cycles after the request; `entry_pass` → `entry_open`=0; returns to IDLE after `entry_req`=0.
- `entry_req`=1, `entry_uni`=1, `rejected_uni`=1 at sample → one-cycle `entry_denied`; `entry_open` stays 0; no second event while `entry_req` stays high.
- `entry_req` and `exit_req` both high from reset → entry served first, exit second; never both events in one cycle.
- No pass sensor, OPEN_TIMEOUT=700 → barrier drops after 700 cycles; `timeout_count`=1. With the macro defined, a one-cycle `car_exited` (same class) follows. Without the macro, no extra event.
- `Start` asserted during OPEN → next cycle all outputs 0 and `busy`=0; a held `entry_req` re-issues `car_entered` after reset.
- 256 forced timeouts with TMO_W=8 → `timeout_count` saturates at 255.

Source files
------------

// File: rtl/gate_controller.sv
// gate_controller
//
// Barrier-gate front end for the parking manager. Entry-lane and exit-lane
// requests are serialised into single-cycle manager events. The manager's
// rejected / rejected_uni response decides whether the barrier opens. The
// barrier is timed while open, and the FSM re-arms only after the car has
// left the lane loop.
//
// Optional build macro:
//   GATE_TIMEOUT_REVERT_EN - when defined, a barrier timeout issues a
//   compensating opposite-direction event (REVERT state), so the manager's
//   occupancy matches reality. When undefined, the REVERT state is not built
//   and a timeout only bumps timeout_count.
//
// Parameters:
//   OPEN_TIMEOUT  max cycles a barrier stays open waiting for its pass sensor
//   RESP_DELAY    cycles from the event pulse to sampling the manager response (>=1)
//   TMO_W         width of timeout_count
//
// Ports:
//   CLK                 clock, rising edge
//   Start               synchronous active-high reset
//   entry_req/exit_req  lane loop occupied (level)
//   entry_uni/exit_uni  car class of the lane, sampled at grant
//   entry_pass/exit_pass barrier pass sensors
//   rejected/rejected_uni manager response per class
//   car_entered/car_exited + is_uni_* one-cycle events with class qualifier
//   entry_open/exit_open barrier raised
//   entry_denied/exit_denied one-cycle rejection pulses
//   busy                FSM not idle
//   timeout_count       saturating count of barrier timeouts
module gate_controller #(
    parameter int OPEN_TIMEOUT = 700,
    parameter int RESP_DELAY   = 1,
    parameter int TMO_W        = 8
) (
    input  logic             CLK,
    input  logic             Start,
    input  logic             entry_req,
    input  logic             entry_uni,
    input  logic             exit_req,
    input  logic             exit_uni,
    input  logic             entry_pass,
    input  logic             exit_pass,
    input  logic             rejected,
    input  logic             rejected_uni,
    output logic             car_entered,
    output logic             is_uni_car_entered,
    output logic             car_exited,
    output logic             is_uni_car_exited,
    output logic             entry_open,
    output logic             exit_open,
    output logic             entry_denied,
    output logic             exit_denied,
    output logic             busy,
    output logic [TMO_W-1:0] timeout_count
);

    localparam int TMR_W = (OPEN_TIMEOUT > 1) ? $clog2(OPEN_TIMEOUT) : 1;
    localparam int DLY_W = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(OPEN_TIMEOUT - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(RESP_DELAY - 1);
    localparam logic LANE_ENTRY = 1'b0;
    localparam logic LANE_EXIT  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_OPEN   = 3'd3,
        S_DENY   = 3'd4,
`ifdef GATE_TIMEOUT_REVERT_EN
        S_REVERT = 3'd5,
`endif
        S_CLEAR  = 3'd6
    } state_e;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
        return (v == {TMO_W{1'b1}}) ? v : v + TMO_W'(1);
    endfunction

    // Control state
    state_e            state_q, state_d;
    logic              last_q, last_d;     // lane granted most recently
    logic [TMR_W-1:0]  tmr_q, tmr_d;       // open-time counter
    logic [DLY_W-1:0]  dly_q, dly_d;       // response delay counter
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    // Latched transaction data
    logic              lane_q, lane_d;
    logic              uni_q, uni_d;

    // Registered outputs
    logic ent_q, ent_d, ent_uni_q, ent_uni_d;
    logic ext_q, ext_d, ext_uni_q, ext_uni_d;
    logic eopen_q, eopen_d, xopen_q, xopen_d;
    logic eden_q, eden_d, xden_q, xden_d;
    logic busy_q, busy_d;

    logic grant_exit;
    logic lane_req;
    logic lane_pass;
    logic sample_rej;

    assign lane_req   = (lane_q == LANE_EXIT) ? exit_req  : entry_req;
    assign lane_pass  = (lane_q == LANE_EXIT) ? exit_pass : entry_pass;
    assign sample_rej = uni_q ? rejected_uni : rejected;

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        tmr_d      = tmr_q;
        dly_d      = dly_q;
        tmo_d      = tmo_q;
        lane_d     = lane_q;
        uni_d      = uni_q;
        // On a tie the lane opposite the last grant wins.
        grant_exit = exit_req && (!entry_req || (last_q == LANE_ENTRY));

        case (state_q)
            S_IDLE: begin
                if (entry_req || exit_req) begin
                    lane_d  = grant_exit;
                    uni_d   = grant_exit ? exit_uni : entry_uni;
                    last_d  = grant_exit;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                dly_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dly_q == DLY_LAST) begin
                    if (sample_rej) begin
                        state_d = S_DENY;
                    end else begin
                        tmr_d   = '0;
                        state_d = S_OPEN;
                    end
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            S_OPEN: begin
                // Pass sensor has priority over a coincident timeout.
                if (lane_pass) begin
                    state_d = S_CLEAR;
                end else if (tmr_q == TMR_LAST) begin
                    tmo_d = sat_inc(tmo_q);
`ifdef GATE_TIMEOUT_REVERT_EN
                    state_d = S_REVERT;
`else
                    state_d = S_CLEAR;
`endif
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_DENY: begin
                state_d = S_CLEAR;
            end
`ifdef GATE_TIMEOUT_REVERT_EN
            S_REVERT: begin
                state_d = S_CLEAR;
            end
`endif
            S_CLEAR: begin
                // Wait for the car to leave the loop so one car is counted once.
                if (!lane_req) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output is a register.
    always_comb begin
        ent_d = (state_d == S_ISSUE) && (lane_d == LANE_ENTRY);
        ext_d = (state_d == S_ISSUE) && (lane_d == LANE_EXIT);
`ifdef GATE_TIMEOUT_REVERT_EN
        // Compensating event runs in the opposite direction with the same class.
        if (state_d == S_REVERT) begin
            ent_d = (lane_d == LANE_EXIT);
            ext_d = (lane_d == LANE_ENTRY);
        end
`endif
        ent_uni_d = ent_d && uni_d;
        ext_uni_d = ext_d && uni_d;
        eopen_d   = (state_d == S_OPEN) && (lane_d == LANE_ENTRY);
        xopen_d   = (state_d == S_OPEN) && (lane_d == LANE_EXIT);
        eden_d    = (state_d == S_DENY) && (lane_d == LANE_ENTRY);
        xden_d    = (state_d == S_DENY) && (lane_d == LANE_EXIT);
        busy_d    = (state_d != S_IDLE);
    end

    // Control and output registers
    always_ff @(posedge CLK) begin
        if (Start) begin
            state_q   <= S_IDLE;
            last_q    <= LANE_EXIT;
            tmr_q     <= '0;
            dly_q     <= '0;
            tmo_q     <= '0;
            ent_q     <= 1'b0;
            ent_uni_q <= 1'b0;
            ext_q     <= 1'b0;
            ext_uni_q <= 1'b0;
            eopen_q   <= 1'b0;
            xopen_q   <= 1'b0;
            eden_q    <= 1'b0;
            xden_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            tmr_q     <= tmr_d;
            dly_q     <= dly_d;
            tmo_q     <= tmo_d;
            ent_q     <= ent_d;
            ent_uni_q <= ent_uni_d;
            ext_q     <= ext_d;
            ext_uni_q <= ext_uni_d;
            eopen_q   <= eopen_d;
            xopen_q   <= xopen_d;
            eden_q    <= eden_d;
            xden_q    <= xden_d;
            busy_q    <= busy_d;
        end
    end

    // Transaction data is only consumed while the FSM is out of IDLE,
    // so it carries no reset.
    always_ff @(posedge CLK) begin
        lane_q <= lane_d;
        uni_q  <= uni_d;
    end

    assign car_entered        = ent_q;
    assign is_uni_car_entered = ent_uni_q;
    assign car_exited         = ext_q;
    assign is_uni_car_exited  = ext_uni_q;
    assign entry_open         = eopen_q;
    assign exit_open          = xopen_q;
    assign entry_denied       = eden_q;
    assign exit_denied        = xden_q;
    assign busy               = busy_q;
    assign timeout_count      = tmo_q;

endmodule
